// File: rtl/ecg_pkg.sv
// Shared widths, default tuning constants and FSM encoding for the ECG R-peak detector.
package ecg_pkg;

  localparam int DATA_W        = 40;
  localparam int RR_W          = 16;
  localparam int REFRACT_N_DEF = 50;
  localparam int MAX_WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_TRACK   = 2'd1,
    ST_REFRACT = 2'd2
  } state_e;

endpackage

// File: rtl/ecg_sat_counter.sv
// Saturating up-counter with clear (highest priority), load and enable.
module ecg_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_out1_wire,
  input  logic         system_reset,
  input  logic         en,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear beats load beats increment; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      cnt_d = ld_val;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared by the asynchronous system reset.
  always_ff @(posedge clk_out1_wire or posedge system_reset) begin
    if (system_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ecg_peak_detector.sv
// R-peak detector sitting between the IIR filter (Out1, ce_out -> sample_valid)
// and the ILA probes. Finds the maximum of each above-threshold excursion,
// reports it with the RR interval to the previous maximum, then blanks the
// input for a refractory period.
module ecg_peak_detector #(
  parameter int DATA_W    = ecg_pkg::DATA_W,
  parameter int RR_W      = ecg_pkg::RR_W,
  parameter int REFRACT_N = ecg_pkg::REFRACT_N_DEF,
  parameter int MAX_WIDTH = ecg_pkg::MAX_WIDTH_DEF
) (
  input  logic                     clk_out1_wire,
  input  logic                     system_reset,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic signed [DATA_W-1:0] threshold,
  output logic                     peak_valid,
  output logic signed [DATA_W-1:0] peak_amp,
  output logic [RR_W-1:0]          rr_interval,
  output logic                     rr_valid,
  output logic [15:0]              peak_count,
  output logic [1:0]               state_dbg
);

  import ecg_pkg::*;

  localparam int WW  = $clog2(MAX_WIDTH + 1);
  localparam int RFW = $clog2(REFRACT_N + 1);

  state_e                    state_q, state_d;
  logic signed [DATA_W-1:0]  max_q, max_d;
  logic [RR_W-1:0]           max_pos_q, max_pos_d;
  logic                      first_q, first_d;
  logic                      peak_valid_q, peak_valid_d;
  logic                      rr_valid_q, rr_valid_d;
  logic signed [DATA_W-1:0]  peak_amp_q, peak_amp_d;
  logic [RR_W-1:0]           rr_interval_q, rr_interval_d;
  logic [15:0]               peak_count_q, peak_count_d;

  logic [RR_W-1:0] since_cnt;
  logic            since_en, since_ld;
  logic [RR_W-1:0] since_ld_val;
  logic [WW-1:0]   width_cnt;
  logic            width_en, width_clr;
  logic [RFW-1:0]  refr_cnt;
  logic            refr_en, refr_clr;
  logic            emit;
  logic            above_thr;

  assign above_thr = (sample_in > threshold);

  // Samples elapsed since the previous peak maximum.
  ecg_sat_counter #(.W(RR_W)) u_since (
    .clk_out1_wire (clk_out1_wire),
    .system_reset  (system_reset),
    .en            (since_en),
    .clr           (1'b0),
    .ld            (since_ld),
    .ld_val        (since_ld_val),
    .cnt           (since_cnt)
  );

  // Samples spent in TRACK, bounds the length of one excursion.
  ecg_sat_counter #(.W(WW)) u_width (
    .clk_out1_wire (clk_out1_wire),
    .system_reset  (system_reset),
    .en            (width_en),
    .clr           (width_clr),
    .ld            (1'b0),
    .ld_val        ({WW{1'b0}}),
    .cnt           (width_cnt)
  );

  // Samples spent blanked in REFRACT.
  ecg_sat_counter #(.W(RFW)) u_refr (
    .clk_out1_wire (clk_out1_wire),
    .system_reset  (system_reset),
    .en            (refr_en),
    .clr           (refr_clr),
    .ld            (1'b0),
    .ld_val        ({RFW{1'b0}}),
    .cnt           (refr_cnt)
  );

  // Next-state, counter control and peak emission; nothing moves without sample_valid.
  always_comb begin
    state_d       = state_q;
    max_d         = max_q;
    max_pos_d     = max_pos_q;
    first_d       = first_q;
    peak_valid_d  = 1'b0;
    rr_valid_d    = 1'b0;
    peak_amp_d    = peak_amp_q;
    rr_interval_d = rr_interval_q;
    peak_count_d  = peak_count_q;
    since_en      = sample_valid;
    since_ld      = 1'b0;
    // After emission the counter restarts at the number of samples already past the maximum.
    since_ld_val  = since_cnt - max_pos_q + RR_W'(1);
    width_en      = 1'b0;
    width_clr     = 1'b0;
    refr_en       = 1'b0;
    refr_clr      = 1'b0;
    emit          = 1'b0;

    if (sample_valid) begin
      case (state_q)
        ST_SEARCH: begin
          if (above_thr) begin
            state_d   = ST_TRACK;
            max_d     = sample_in;
            max_pos_d = since_cnt;
            width_clr = 1'b1;
          end else begin
            state_d = ST_SEARCH;
          end
        end
        ST_TRACK: begin
          if (!above_thr || (width_cnt == WW'(MAX_WIDTH - 1))) begin
            emit = 1'b1;
          end else begin
            width_en = 1'b1;
            // Strict compare: a tie keeps the earlier maximum position.
            if (sample_in > max_q) begin
              max_d     = sample_in;
              max_pos_d = since_cnt;
            end else begin
              max_d = max_q;
            end
          end
        end
        ST_REFRACT: begin
          // The exit sample itself is swallowed; SEARCH evaluates from the next one.
          if (refr_cnt == RFW'(REFRACT_N - 1)) begin
            state_d = ST_SEARCH;
          end else begin
            refr_en = 1'b1;
          end
        end
        default: begin
          state_d = ST_SEARCH;
        end
      endcase

      if (emit) begin
        state_d       = ST_REFRACT;
        refr_clr      = 1'b1;
        peak_valid_d  = 1'b1;
        rr_valid_d    = !first_q;
        first_d       = 1'b0;
        peak_amp_d    = max_q;
        rr_interval_d = max_pos_q;
        peak_count_d  = peak_count_q + 16'd1;
        since_ld      = 1'b1;
      end else begin
        since_ld = 1'b0;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Registered state and outputs; reset discards any peak in progress.
  always_ff @(posedge clk_out1_wire or posedge system_reset) begin
    if (system_reset) begin
      state_q       <= ST_SEARCH;
      max_q         <= '0;
      max_pos_q     <= '0;
      first_q       <= 1'b1;
      peak_valid_q  <= 1'b0;
      rr_valid_q    <= 1'b0;
      peak_amp_q    <= '0;
      rr_interval_q <= '0;
      peak_count_q  <= 16'd0;
    end else begin
      state_q       <= state_d;
      max_q         <= max_d;
      max_pos_q     <= max_pos_d;
      first_q       <= first_d;
      peak_valid_q  <= peak_valid_d;
      rr_valid_q    <= rr_valid_d;
      peak_amp_q    <= peak_amp_d;
      rr_interval_q <= rr_interval_d;
      peak_count_q  <= peak_count_d;
    end
  end

  assign peak_valid  = peak_valid_q;
  assign rr_valid    = rr_valid_q;
  assign peak_amp    = peak_amp_q;
  assign rr_interval = rr_interval_q;
  assign peak_count  = peak_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_ecg_peak_detector.sv
// Directed bench for ecg_peak_detector: known pulse trains with hand-derived peaks and RR intervals.
module tb_ecg_peak_detector;

  logic               clk_out1_wire = 1'b0;
  logic               system_reset;
  logic               sample_valid;
  logic signed [39:0] sample_in;
  logic signed [39:0] threshold;
  logic               peak_valid;
  logic signed [39:0] peak_amp;
  logic [15:0]        rr_interval;
  logic               rr_valid;
  logic [15:0]        peak_count;
  logic [1:0]         state_dbg;

  int errors = 0;
  int checks = 0;

  int     idx;        // valid samples sent since last reset
  int     npeaks;     // peak_valid pulses observed
  int     peak_at;    // index of the valid sample that ended the last peak
  int     max_idx;    // index of the 3000 sample in the last pulse() call
  longint l_amp, l_rr, l_rrv, l_cnt;
  int     prev, t, n0;

  ecg_peak_detector dut (
    .clk_out1_wire (clk_out1_wire),
    .system_reset  (system_reset),
    .sample_valid  (sample_valid),
    .sample_in     (sample_in),
    .threshold     (threshold),
    .peak_valid    (peak_valid),
    .peak_amp      (peak_amp),
    .rr_interval   (rr_interval),
    .rr_valid      (rr_valid),
    .peak_count    (peak_count),
    .state_dbg     (state_dbg)
  );

  always #5 clk_out1_wire = ~clk_out1_wire;

  task automatic chk_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given strobe/sample; records any peak pulse seen afterwards.
  task automatic vstep(input logic v, input longint x);
    int cur;
    cur          = idx;
    sample_valid = v;
    sample_in    = 40'(x);
    @(posedge clk_out1_wire);
    #1;
    if (v) idx++;
    if (peak_valid) begin
      npeaks++;
      peak_at = cur;
      l_amp   = longint'(peak_amp);
      l_rr    = longint'(rr_interval);
      l_rrv   = longint'(rr_valid);
      l_cnt   = longint'(peak_count);
    end
  endtask

  // Standard pulse 1500,3000,2000,500 with 'gap' invalid cycles before each sample.
  task automatic pulse(input int gap);
    longint vals[4];
    vals[0] = 1500; vals[1] = 3000; vals[2] = 2000; vals[3] = 500;
    for (int i = 0; i < 4; i++) begin
      repeat (gap) vstep(1'b0, 64'sd9000);
      if (i == 1) max_idx = idx;
      vstep(1'b1, vals[i]);
    end
  endtask

  task automatic chk_peak(input string tag, input int exp_n, input longint exp_amp,
                          input longint exp_rr, input longint exp_rrv,
                          input longint exp_cnt, input int exp_at);
    chk_eq({tag, "_npeaks"}, npeaks, exp_n);
    chk_eq({tag, "_amp"}, l_amp, exp_amp);
    chk_eq({tag, "_rr"}, l_rr, exp_rr);
    chk_eq({tag, "_rrv"}, l_rrv, exp_rrv);
    chk_eq({tag, "_cnt"}, l_cnt, exp_cnt);
    chk_eq({tag, "_at"}, peak_at, exp_at);
  endtask

  initial begin
    system_reset = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    threshold    = 40'sd1000;
    idx = 0; npeaks = 0; peak_at = -1; max_idx = 0;
    l_amp = 0; l_rr = 0; l_rrv = 0; l_cnt = 0;

    // Reset state
    repeat (3) @(posedge clk_out1_wire);
    #1;
    chk_eq("rst_pv", peak_valid, 0);
    chk_eq("rst_rrv", rr_valid, 0);
    chk_eq("rst_amp", peak_amp, 0);
    chk_eq("rst_rr", rr_interval, 0);
    chk_eq("rst_cnt", peak_count, 0);
    chk_eq("rst_state", state_dbg, 0);
    system_reset = 1'b0;

    // First peak: 0,0,1500,3000,2000,500 -> max at idx 3, ends at idx 5
    vstep(1'b1, 0); vstep(1'b1, 0);
    pulse(0);
    chk_peak("p1", 1, 3000, 3, 0, 1, 5);
    chk_eq("p1_state", state_dbg, 2);
    prev = max_idx;

    // Same pulse with its maximum 200 samples later
    while (idx < 202) vstep(1'b1, 0);
    pulse(0);
    chk_peak("p2", 2, 3000, 200, 1, 2, 205);
    prev = max_idx;

    // Pulse 10 samples after the previous end lands in refractory: ignored
    repeat (10) vstep(1'b1, 0);
    pulse(0);
    while (idx < 300) vstep(1'b1, 0);
    chk_eq("refr_npeaks", npeaks, 2);
    chk_eq("refr_cnt", peak_count, 2);
    chk_eq("refr_state", state_dbg, 0);

    // Plateau at 5000 for 100 samples: forced end 64 samples after the trigger
    t = idx;
    repeat (100) vstep(1'b1, 5000);
    chk_peak("wide", 3, 5000, t - prev, 1, 3, t + 64);
    chk_eq("wide_state", state_dbg, 2);
    while (idx < 430) vstep(1'b1, 0);
    chk_eq("wide_exit", state_dbg, 0);
    prev = t;

    // 1-in-4 strobe with garbage on idle cycles
    for (int i = 0; i < 5; i++) begin
      repeat (3) vstep(1'b0, 64'sd9000);
      vstep(1'b1, 0);
    end
    pulse(3);
    chk_peak("gap", 4, 3000, max_idx - prev, 1, 4, max_idx + 2);
    chk_eq("gap_rr_val", l_rr, 136);
    repeat (60) vstep(1'b1, 0);
    chk_eq("gap_state", state_dbg, 0);

    // Reset in the middle of TRACK
    vstep(1'b1, 0); vstep(1'b1, 1500); vstep(1'b1, 3000);
    chk_eq("trk_state", state_dbg, 1);
    #2 system_reset = 1'b1;
    #1;
    chk_eq("arst_pv", peak_valid, 0);
    chk_eq("arst_amp", peak_amp, 0);
    chk_eq("arst_rr", rr_interval, 0);
    chk_eq("arst_cnt", peak_count, 0);
    chk_eq("arst_state", state_dbg, 0);
    @(posedge clk_out1_wire);
    #1 system_reset = 1'b0;
    idx = 0;
    n0 = npeaks;
    repeat (60) vstep(1'b1, 0);
    chk_eq("arst_nopulse", npeaks, n0);
    chk_eq("arst_cnt2", peak_count, 0);

    // First peak after reset, then a 70000-sample silence saturates the interval
    pulse(0);
    chk_peak("p5", n0 + 1, 3000, 61, 0, 1, 63);
    repeat (70000) vstep(1'b1, 0);
    pulse(0);
    chk_peak("sat", n0 + 2, 3000, 65535, 1, 2, max_idx + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
